// File: rtl/signal_sampler_pkg.sv
// Shared definitions for the signal capture block.
//   FLAG_FIRST / FLAG_WRAP : bit positions inside the 2-bit record flag field
//   cap_state_e            : capture FSM encoding
//   rec_width()            : packed record width {data, ts, flags}
package signal_sampler_pkg;

  localparam int FLAG_FIRST = 0;
  localparam int FLAG_WRAP  = 1;
  localparam int FLAG_W     = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } cap_state_e;

  function automatic int rec_width(input int dw, input int tw);
    return dw + tw + FLAG_W;
  endfunction

endpackage

// File: rtl/sampler_fifo.sv
// First-word-fall-through record buffer.
//   clk, rst_n        : clock, async active-low reset (empties the buffer)
//   push, push_data   : write request; taken when not full, or when full
//                       and a pop happens in the same cycle
//   pop               : remove head entry (ignored when empty)
//   pop_data          : head entry, forced to zero while empty
//   full, empty       : occupancy flags
module sampler_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        do_push, do_pop;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CW'(DEPTH));
  assign do_pop   = pop & ~empty;
  // A full buffer still takes a push when the head leaves in the same cycle.
  assign do_push  = push & (~full | do_pop);
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/signal_capture.sv
// Change/wrap capture of a synchronized sample bus into a record stream.
//   clk, rst_n            : clock, async active-low reset
//   enable                : level capture enable (IDLE -> ARM -> RUN)
//   data_in               : sample bus, already in the clk domain
//   rec_valid/ready       : record handshake, head popped on valid & ready
//   rec_data/ts/flags     : head record fields (flags: first, wrap)
//   overflow              : sticky drop indicator
//   clear_overflow        : synchronous clear; a same-cycle drop wins
module signal_capture
  import signal_sampler_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int TS_WIDTH   = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  rec_valid,
  input  logic                  rec_ready,
  output logic [DATA_WIDTH-1:0] rec_data,
  output logic [TS_WIDTH-1:0]   rec_ts,
  output logic [1:0]            rec_flags,
  output logic                  overflow,
  input  logic                  clear_overflow
);

  localparam int REC_W = rec_width(DATA_WIDTH, TS_WIDTH);

  cap_state_e            state_q, state_d;
  logic [TS_WIDTH-1:0]   ts_q, ts_d;
  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic                  overflow_q, overflow_d;

  logic                  push, pop, drop;
  logic [TS_WIDTH-1:0]   push_ts;
  logic [FLAG_W-1:0]     push_flags;
  logic [REC_W-1:0]      fifo_dout;
  logic                  fifo_full, fifo_empty;

  always_comb begin
    state_d    = state_q;
    ts_d       = ts_q;
    prev_d     = prev_q;
    push       = 1'b0;
    push_ts    = '0;
    push_flags = '0;
    case (state_q)
      ST_IDLE: if (enable) state_d = ST_ARM;
      ST_ARM: begin
        if (!enable) state_d = ST_IDLE;
        else begin
          state_d                = ST_RUN;
          ts_d                   = '0;
          prev_d                 = data_in;
          push                   = 1'b1;
          push_flags[FLAG_FIRST] = 1'b1;
        end
      end
      ST_RUN: begin
        if (!enable) state_d = ST_IDLE;
        else begin
          ts_d    = ts_q + TS_WIDTH'(1);
          prev_d  = data_in;
          push_ts = ts_q;
          // Wrap marker absorbs a coincident change: one record, flags=10.
          if (&ts_q) begin
            push                  = 1'b1;
            push_flags[FLAG_WRAP] = 1'b1;
          end else if (data_in != prev_q) begin
            push = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pop  = rec_valid & rec_ready;
  assign drop = push & fifo_full & ~pop;

  always_comb begin
    overflow_d = overflow_q;
    if (clear_overflow) overflow_d = 1'b0;
    if (drop)           overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ts_q       <= '0;
      prev_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_d;
      prev_q     <= prev_d;
      overflow_q <= overflow_d;
    end
  end

  sampler_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({data_in, push_ts, push_flags}),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rec_valid = ~fifo_empty;
  assign rec_data  = fifo_dout[REC_W-1 -: DATA_WIDTH];
  assign rec_ts    = fifo_dout[FLAG_W +: TS_WIDTH];
  assign rec_flags = fifo_dout[FLAG_W-1:0];
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_signal_capture.sv
// Scoreboard bench for signal_capture (8-bit data, 4-bit ts, depth 4).
module tb_signal_capture;

  localparam int DW    = 8;
  localparam int TW    = 4;
  localparam int DEPTH = 4;
  localparam int RW    = DW + TW + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          rec_valid;
  logic          rec_ready = 1'b0;
  logic [DW-1:0] rec_data;
  logic [TW-1:0] rec_ts;
  logic [1:0]    rec_flags;
  logic          overflow;
  logic          clear_overflow = 1'b0;

  signal_capture #(
    .DATA_WIDTH (DW),
    .TS_WIDTH   (TW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .data_in        (data_in),
    .rec_valid      (rec_valid),
    .rec_ready      (rec_ready),
    .rec_data       (rec_data),
    .rec_ts         (rec_ts),
    .rec_flags      (rec_flags),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // reference: expected records in order, plus capture-side state
  logic [RW-1:0] m_q[$];
  int            m_state;
  logic [TW-1:0] m_ts;
  logic [DW-1:0] m_prev;
  logic          m_ov;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic m_reset();
    m_q.delete();
    m_state = 0;
    m_ts    = '0;
    m_prev  = '0;
    m_ov    = 1'b0;
  endtask

  // One clock: predict from pre-edge inputs, advance, compare 1ns after edge.
  task automatic tick();
    logic          pop, push, full;
    logic [RW-1:0] rec;
    int            ns;
    logic [TW-1:0] nts;
    logic [DW-1:0] nprev;
    pop   = (m_q.size() != 0) && rec_ready;
    push  = 1'b0;
    rec   = '0;
    ns    = m_state;
    nts   = m_ts;
    nprev = m_prev;
    if (m_state == 0) begin
      if (enable) ns = 1;
    end else if (!enable) begin
      ns = 0;
    end else if (m_state == 1) begin
      ns = 2; nts = '0; nprev = data_in; push = 1'b1;
      rec = {data_in, 4'h0, 2'b01};
    end else begin
      nts = TW'(m_ts + 1); nprev = data_in;
      if (m_ts == 4'hF) begin
        push = 1'b1; rec = {data_in, 4'hF, 2'b10};
      end else if (data_in != m_prev) begin
        push = 1'b1; rec = {data_in, m_ts, 2'b00};
      end
    end
    @(posedge clk);
    full = (m_q.size() == DEPTH);
    if (pop) m_q.delete(0);
    if (push && (!full || pop)) m_q.push_back(rec);
    if (push && full && !pop) m_ov = 1'b1;
    else if (clear_overflow)  m_ov = 1'b0;
    m_state = ns; m_ts = nts; m_prev = nprev;
    cyc++;
    #1;
    chk("sb_valid", 32'(rec_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) chk("sb_head", 32'({rec_data, rec_ts, rec_flags}), 32'(m_q[0]));
    chk("sb_overflow", 32'(overflow), 32'(m_ov));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("rst_valid", 32'(rec_valid), 32'd0);
    chk("rst_fields", 32'({rec_data, rec_ts, rec_flags}), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int nrec, nw, w0, w1;

  initial begin
    do_reset();

    // arm record, then silence while input is static
    enable = 1'b1; data_in = 8'h00; rec_ready = 1'b1;
    tick();
    chk("arm_not_yet", 32'(rec_valid), 32'd0);
    tick();
    chk("first_rec", 32'({rec_valid, rec_data, rec_ts, rec_flags}), 32'({1'b1, 8'h00, 4'h0, 2'b01}));
    nrec = 0;
    repeat (10) begin tick(); if (rec_valid) nrec++; end
    chk("quiet_10", 32'(nrec), 32'd0);

    // change at ts=7
    do_reset();
    enable = 1'b1; data_in = 8'h00; rec_ready = 1'b1;
    tick(); tick();
    repeat (7) tick();
    chk("pre_change", 32'(rec_valid), 32'd0);
    data_in = 8'h5A;
    tick();
    chk("change_rec", 32'({rec_valid, rec_data, rec_ts, rec_flags}), 32'({1'b1, 8'h5A, 4'h7, 2'b00}));
    tick();

    // timestamp wrap markers, 16 cycles apart
    do_reset();
    enable = 1'b1; data_in = 8'h00; rec_ready = 1'b1;
    tick(); tick();
    nw = 0; w0 = 0; w1 = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rec_valid && rec_flags == 2'b10) begin
        if (nw == 0) begin
          w0 = cyc;
          chk("wrap_ts", 32'(rec_ts), 32'hF);
        end else w1 = cyc;
        nw++;
      end
    end
    chk("wrap_count", 32'(nw), 32'd2);
    chk("wrap_gap", 32'(w1 - w0), 32'd16);
    for (int i = 0; i < 20 && m_ts != 4'hF; i++) tick();
    data_in = 8'hC3;
    tick();
    chk("wrap_change", 32'({rec_valid, rec_data, rec_ts, rec_flags}), 32'({1'b1, 8'hC3, 4'hF, 2'b10}));
    tick();
    chk("wrap_single", 32'(rec_valid), 32'd0);

    // six changes into a 4-deep buffer, then ordered drain
    do_reset();
    enable = 1'b1; data_in = 8'h00; rec_ready = 1'b1;
    tick(); tick(); tick();
    rec_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin data_in = DW'(8'h11 * i); tick(); end
    chk("ovf_set", 32'(overflow), 32'd1);
    rec_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_valid", 32'(rec_valid), 32'd1);
      chk("drain_data", 32'(rec_data), 32'(8'h11 * i));
      tick();
    end
    chk("drain_end", 32'(rec_valid), 32'd0);
    clear_overflow = 1'b1; tick(); clear_overflow = 1'b0;
    chk("ovf_clear", 32'(overflow), 32'd0);

    // clear together with a drop: drop wins
    do_reset();
    enable = 1'b1; data_in = 8'h00; rec_ready = 1'b0;
    tick(); tick();
    for (int i = 1; i <= 3; i++) begin data_in = DW'(8'h20 + i); tick(); end
    data_in = 8'h30; clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("ovf_drop_wins", 32'(overflow), 32'd1);
    clear_overflow = 1'b1; tick(); clear_overflow = 1'b0;
    chk("ovf_clear2", 32'(overflow), 32'd0);

    // full buffer, change and pop together: accepted, no overflow
    data_in = 8'h31; rec_ready = 1'b1;
    tick();
    rec_ready = 1'b0;
    chk("full_pop_ovf", 32'(overflow), 32'd0);

    // idle keeps records; re-arm appends without flushing
    enable = 1'b0;
    tick();
    data_in = 8'h77;
    tick();
    rec_ready = 1'b1; tick(); rec_ready = 1'b0;
    enable = 1'b1;
    tick(); tick();

    // reset in the middle of a drain
    rec_ready = 1'b1;
    tick();
    chk("mid_drain_valid", 32'(rec_valid), 32'd1);
    enable = 1'b0;
    do_reset();
    repeat (4) tick();
    chk("post_reset_empty", 32'(rec_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
